// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C register slave: FSM state encoding,
// bus-level constants and the pointer-width helper.
package i2c_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_PTR,
        ST_PTR_ACK,
        ST_WDATA,
        ST_WDATA_ACK,
        ST_RDATA,
        ST_RDATA_MACK,
        ST_WAIT
    } state_t;

    localparam logic ACK         = 1'b0;
    localparam logic NACK        = 1'b1;
    localparam int   SYNC_STAGES = 2;
    localparam logic RW_WRITE    = 1'b0;
    localparam logic RW_READ     = 1'b1;

    // Pointer width is clog2 of the bank size, never below one bit.
    function automatic int ptr_width(input int num_regs);
        return (num_regs <= 2) ? 1 : $clog2(num_regs);
    endfunction

endpackage

// File: rtl/i2c_reg_slave_line_cond.sv
// Conditions one open-drain bus line: 2-FF synchroniser, optional counter
// glitch filter (enabled by I2C_GLITCH_FILTER_EN), rise/fall detection on
// the conditioned level.
module i2c_line_cond
    import i2c_pkg::*;
#(
    parameter int FILTER_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic line_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;
    logic                   level;

    // Shift the raw pad value through the synchroniser chain.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], line_i};
    end

    // Synchroniser registers; idle bus level is high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) sync_q <= '1;
        else       sync_q <= sync_d;
    end

`ifdef I2C_GLITCH_FILTER_EN
    localparam int CNT_W = $clog2(FILTER_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             filt_q, filt_d;

    // Accept a new level only after FILTER_CYCLES consecutive differing samples.
    always_comb begin
        cnt_d  = '0;
        filt_d = filt_q;
        if (sync_q[SYNC_STAGES-1] != filt_q) begin
            if (cnt_q == CNT_W'(FILTER_CYCLES - 1)) filt_d = sync_q[SYNC_STAGES-1];
            else                                    cnt_d  = cnt_q + 1'b1;
        end
    end

    // Filter state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            filt_q <= 1'b1;
        end else begin
            cnt_q  <= cnt_d;
            filt_q <= filt_d;
        end
    end

    assign level = filt_q;
`else
    assign level = sync_q[SYNC_STAGES-1];
`endif

    // Remember the previous conditioned level for edge detection.
    always_comb begin
        prev_d = level;
    end

    // Edge-detect history register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) prev_q <= 1'b1;
        else       prev_q <= prev_d;
    end

    assign level_o = level;
    assign rise_o  = level & ~prev_q;
    assign fall_o  = ~level & prev_q;

endmodule

// File: rtl/i2c_reg_slave.sv
// I2C slave (7-bit address) in front of a NUM_REGS x 8 register bank.
// Write: addr+W, pointer byte, then data bytes with auto-increment/wrap.
// Read:  addr+R returns bytes from rd_data_i at the pointer; master ACK
// advances the pointer. Out-of-range pointer bytes are NACKed.
// Optional input glitch filter: define I2C_GLITCH_FILTER_EN.
module i2c_reg_slave
    import i2c_pkg::*;
#(
    parameter logic [6:0] ADDRESS       = 7'h4A,
    parameter int         NUM_REGS      = 9,
    parameter int         FILTER_CYCLES = 4,
    localparam int        PTR_W         = ptr_width(NUM_REGS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             scl_i,
    output logic             scl_o,
    input  logic             sda_i,
    output logic             sda_o,
    output logic             wr_en_o,
    output logic [PTR_W-1:0] wr_addr_o,
    output logic [7:0]       wr_data_o,
    output logic [PTR_W-1:0] rd_addr_o,
    input  logic [7:0]       rd_data_i,
    output logic             address_valid_o,
    output logic             busy_o,
    output state_t           dbg_state_o
);

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;

    i2c_line_cond #(.FILTER_CYCLES(FILTER_CYCLES)) u_scl_cond (
        .clk     (clk),
        .reset   (reset),
        .line_i  (scl_i),
        .level_o (scl_lvl),
        .rise_o  (scl_rise),
        .fall_o  (scl_fall)
    );

    i2c_line_cond #(.FILTER_CYCLES(FILTER_CYCLES)) u_sda_cond (
        .clk     (clk),
        .reset   (reset),
        .line_i  (sda_i),
        .level_o (sda_lvl),
        .rise_o  (sda_rise),
        .fall_o  (sda_fall)
    );

    state_t           state_q, state_d;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic             sda_q, sda_d;
    logic             phase_q, phase_d;      // ACK phase: 0 = waiting to drive, 1 = driving / master ACKed
    logic             rw_q, rw_d;
    logic             busy_q, busy_d;
    logic             wr_en_q, wr_en_d;
    logic [PTR_W-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]       wr_data_q, wr_data_d;
    logic             addr_valid_q, addr_valid_d;

    logic             start_det, stop_det;
    logic [7:0]       byte_in;
    logic [PTR_W-1:0] ptr_inc;

    assign start_det = sda_fall & scl_lvl;
    assign stop_det  = sda_rise & scl_lvl;
    assign byte_in   = {shift_q[6:0], sda_lvl};
    assign ptr_inc   = (ptr_q == PTR_W'(NUM_REGS - 1)) ? '0 : ptr_q + 1'b1;

    // Next-state and output logic; START/STOP override every state.
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        ptr_d        = ptr_q;
        sda_d        = sda_q;
        phase_d      = phase_q;
        rw_d         = rw_q;
        busy_d       = busy_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        addr_valid_d = 1'b0;

        if (stop_det) begin
            state_d = ST_IDLE;
            sda_d   = 1'b1;
            busy_d  = 1'b0;
            phase_d = 1'b0;
        end else if (start_det) begin
            state_d   = ST_ADDR;
            sda_d     = 1'b1;
            bit_cnt_d = '0;
            phase_d   = 1'b0;
        end else begin
            unique case (state_q)
                ST_ADDR: begin
                    if (scl_rise) begin
                        shift_d   = byte_in;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            bit_cnt_d = '0;
                            phase_d   = 1'b0;
                            if (byte_in[7:1] == ADDRESS) begin
                                addr_valid_d = 1'b1;
                                busy_d       = 1'b1;
                                rw_d         = byte_in[0];
                                state_d      = ST_ADDR_ACK;
                            end else begin
                                busy_d  = 1'b0;
                                state_d = ST_WAIT;
                            end
                        end
                    end
                end
                ST_PTR: begin
                    if (scl_rise) begin
                        shift_d   = byte_in;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            bit_cnt_d = '0;
                            phase_d   = 1'b0;
                            if ({1'b0, byte_in} < 9'(NUM_REGS)) begin
                                ptr_d   = byte_in[PTR_W-1:0];
                                state_d = ST_PTR_ACK;
                            end else begin
                                state_d = ST_WAIT;
                            end
                        end
                    end
                end
                ST_WDATA: begin
                    if (scl_rise) begin
                        shift_d   = byte_in;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            bit_cnt_d = '0;
                            phase_d   = 1'b0;
                            wr_en_d   = 1'b1;
                            wr_addr_d = ptr_q;
                            wr_data_d = byte_in;
                            ptr_d     = ptr_inc;
                            state_d   = ST_WDATA_ACK;
                        end
                    end
                end
                ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: begin
                    // First SCL fall pulls SDA low, second one ends the ACK slot.
                    if (scl_fall) begin
                        if (!phase_q) begin
                            sda_d   = ACK;
                            phase_d = 1'b1;
                        end else begin
                            phase_d   = 1'b0;
                            sda_d     = 1'b1;
                            bit_cnt_d = '0;
                            if (state_q != ST_ADDR_ACK) begin
                                state_d = ST_WDATA;
                            end else if (rw_q == RW_WRITE) begin
                                state_d = ST_PTR;
                            end else begin
                                shift_d = rd_data_i;
                                sda_d   = rd_data_i[7];
                                state_d = ST_RDATA;
                            end
                        end
                    end
                end
                ST_RDATA: begin
                    // Bit 7 was already driven on entry; each fall presents the next bit.
                    if (scl_rise) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall) begin
                        if (bit_cnt_q == 4'd8) begin
                            sda_d     = 1'b1;
                            bit_cnt_d = '0;
                            phase_d   = 1'b0;
                            state_d   = ST_RDATA_MACK;
                        end else begin
                            sda_d   = shift_q[6];
                            shift_d = {shift_q[6:0], 1'b0};
                        end
                    end
                end
                ST_RDATA_MACK: begin
                    if (scl_rise) begin
                        if (sda_lvl == NACK) begin
                            state_d = ST_WAIT;
                        end else begin
                            ptr_d   = ptr_inc;
                            phase_d = 1'b1;
                        end
                    end else if (scl_fall && phase_q) begin
                        phase_d   = 1'b0;
                        shift_d   = rd_data_i;
                        sda_d     = rd_data_i[7];
                        bit_cnt_d = '0;
                        state_d   = ST_RDATA;
                    end
                end
                ST_IDLE, ST_WAIT: begin
                    sda_d = 1'b1;
                end
                default: begin
                    state_d = ST_IDLE;
                    sda_d   = 1'b1;
                end
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            ptr_q        <= '0;
            sda_q        <= 1'b1;
            phase_q      <= 1'b0;
            rw_q         <= RW_WRITE;
            busy_q       <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            addr_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            ptr_q        <= ptr_d;
            sda_q        <= sda_d;
            phase_q      <= phase_d;
            rw_q         <= rw_d;
            busy_q       <= busy_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            addr_valid_q <= addr_valid_d;
        end
    end

    assign scl_o           = 1'b1;
    assign sda_o           = sda_q;
    assign wr_en_o         = wr_en_q;
    assign wr_addr_o       = wr_addr_q;
    assign wr_data_o       = wr_data_q;
    assign rd_addr_o       = ptr_q;
    assign address_valid_o = addr_valid_q;
    assign busy_o          = busy_q;
    assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_i2c_reg_slave.sv
// Bench for i2c_reg_slave: bit-level I2C master tasks, a register-bank model
// behind rd_data_i, and a transaction-level reference of the register map.
module tb_i2c_reg_slave;
    import i2c_pkg::*;

    localparam int NUM_REGS = 9;
    localparam int PTR_W    = 4;
    localparam int Q        = 8;    // quarter SCL period in clk cycles

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic             scl_m, sda_m;
    logic             scl_i, sda_i, scl_o, sda_o;
    logic             wr_en_o, address_valid_o, busy_o;
    logic [PTR_W-1:0] wr_addr_o, rd_addr_o;
    logic [7:0]       wr_data_o, rd_data_i;
    state_t           dbg_state;

    assign scl_i = scl_m & scl_o;
    assign sda_i = sda_m & sda_o;

    i2c_reg_slave #(.ADDRESS(7'h4A), .NUM_REGS(NUM_REGS), .FILTER_CYCLES(4)) dut (
        .clk             (clk),
        .reset           (reset),
        .scl_i           (scl_i),
        .scl_o           (scl_o),
        .sda_i           (sda_i),
        .sda_o           (sda_o),
        .wr_en_o         (wr_en_o),
        .wr_addr_o       (wr_addr_o),
        .wr_data_o       (wr_data_o),
        .rd_addr_o       (rd_addr_o),
        .rd_data_i       (rd_data_i),
        .address_valid_o (address_valid_o),
        .busy_o          (busy_o),
        .dbg_state_o     (dbg_state)
    );

    // ---------------- fabric register bank ----------------
    logic [7:0] fab [NUM_REGS] = '{default: 8'h00};

    always_comb begin
        rd_data_i = 8'h00;
        for (int i = 0; i < NUM_REGS; i++)
            if (rd_addr_o == PTR_W'(i)) rd_data_i = fab[i];
    end

    // ---------------- bus monitor ----------------
    logic [15:0] got_q[$];
    int   av_cnt  = 0;
    int   low_cnt = 0;
    int   dbl_cnt = 0;
    logic wr_en_prev = 1'b0;

    always @(negedge clk) begin
        if (wr_en_o) begin
            got_q.push_back({4'h0, wr_addr_o, wr_data_o});
            if (int'(wr_addr_o) < NUM_REGS) fab[wr_addr_o] = wr_data_o;
        end
        if (wr_en_o && wr_en_prev) dbl_cnt++;
        wr_en_prev = wr_en_o;
        if (address_valid_o) av_cnt++;
        if (!sda_o) low_cnt++;
    end

    // ---------------- reference model ----------------
    logic [7:0]  ref_mem [NUM_REGS] = '{default: 8'h00};
    int          ref_ptr = 0;
    logic [15:0] exp_q[$];
    logic [7:0]  wbuf [8];

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic compare_writes();
        logic [15:0] g, e;
        check("wr_count", got_q.size(), exp_q.size());
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            check("wr_addr_data", g, e);
        end
        got_q.delete();
        exp_q.delete();
        check("wr_single_cycle", dbl_cnt, 0);
        check("ptr_model", rd_addr_o, ref_ptr);
    endtask

    // ---------------- driver tasks ----------------
    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_start();
        sda_m = 1'b1; wait_clk(Q);
        scl_m = 1'b1; wait_clk(Q);
        sda_m = 1'b0; wait_clk(Q);
        scl_m = 1'b0; wait_clk(Q);
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; wait_clk(Q);
        scl_m = 1'b1; wait_clk(Q);
        sda_m = 1'b1; wait_clk(2 * Q);
    endtask

    task automatic send_bit(input logic b);
        sda_m = b;    wait_clk(Q);
        scl_m = 1'b1; wait_clk(2 * Q);
        scl_m = 1'b0; wait_clk(Q);
    endtask

    task automatic recv_bit(output logic b);
        sda_m = 1'b1; wait_clk(Q);
        scl_m = 1'b1; wait_clk(Q);
        b = sda_i;    wait_clk(Q);
        scl_m = 1'b0; wait_clk(Q);
    endtask

    task automatic send_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        recv_bit(ack);
    endtask

    task automatic recv_byte(output logic [7:0] d, input logic mack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            recv_bit(b);
            d[i] = b;
        end
        send_bit(mack);
    endtask

    // Write transaction: pointer byte then len bytes from wbuf.
    task automatic do_write(input int ptr, input int len);
        logic ack;
        logic in_range;
        in_range = (ptr < NUM_REGS);
        bus_start();
        send_byte(8'h94, ack);
        check("wr_addr_ack", ack, ACK);
        check("busy_after_match", busy_o, 1'b1);
        send_byte(8'(ptr), ack);
        check("ptr_ack", ack, in_range ? ACK : NACK);
        if (in_range) ref_ptr = ptr;
        for (int k = 0; k < len; k++) begin
            send_byte(wbuf[k], ack);
            check("data_ack", ack, in_range ? ACK : NACK);
            if (in_range) begin
                ref_mem[ref_ptr] = wbuf[k];
                exp_q.push_back({8'(ref_ptr), wbuf[k]});
                ref_ptr = (ref_ptr + 1) % NUM_REGS;
            end
        end
        bus_stop();
        check("busy_after_stop", busy_o, 1'b0);
        compare_writes();
    endtask

    // Read transaction of len bytes; ptr < 0 reads from the current pointer.
    task automatic do_read(input int ptr, input int len);
        logic       ack;
        logic [7:0] d;
        bus_start();
        if (ptr >= 0) begin
            send_byte(8'h94, ack);
            check("rd_waddr_ack", ack, ACK);
            send_byte(8'(ptr), ack);
            check("rd_ptr_ack", ack, ACK);
            ref_ptr = ptr;
            bus_start();
        end
        send_byte(8'h95, ack);
        check("rd_addr_ack", ack, ACK);
        for (int k = 0; k < len; k++) begin
            recv_byte(d, (k == len - 1) ? NACK : ACK);
            check("rd_data", d, ref_mem[ref_ptr]);
            if (k < len - 1) ref_ptr = (ref_ptr + 1) % NUM_REGS;
        end
        check("rd_wait_state", dbg_state, ST_WAIT);
        check("rd_busy", busy_o, 1'b1);
        bus_stop();
        check("rd_busy_after_stop", busy_o, 1'b0);
        compare_writes();
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        logic ack;
        int   av0, low0, len;

        scl_m = 1'b1;
        sda_m = 1'b1;
        reset = 1'b1;
        wait_clk(5);
        check("rst_sda_o", sda_o, 1'b1);
        check("rst_scl_o", scl_o, 1'b1);
        check("rst_wr_en", wr_en_o, 1'b0);
        check("rst_wr_addr", wr_addr_o, 0);
        check("rst_wr_data", wr_data_o, 8'h00);
        check("rst_addr_valid", address_valid_o, 1'b0);
        check("rst_busy", busy_o, 1'b0);
        check("rst_ptr", rd_addr_o, 0);
        check("rst_state", dbg_state, ST_IDLE);
        reset = 1'b0;
        wait_clk(5);

        // Write burst from pointer 0.
        av0 = av_cnt;
        wbuf[0] = 8'hAB; wbuf[1] = 8'h36; wbuf[2] = 8'h84;
        do_write(0, 3);
        check("burst_addr_valid", av_cnt - av0, 1);

        // Pointer wrap 8 -> 0.
        wbuf[0] = 8'h11; wbuf[1] = 8'h22;
        do_write(8, 2);

        // Read with repeated start: 5A at 2, 0D at 3.
        wbuf[0] = 8'h5A; wbuf[1] = 8'h0D;
        do_write(2, 2);
        do_read(2, 2);

        // Address mismatch.
        av0  = av_cnt;
        low0 = low_cnt;
        bus_start();
        send_byte(8'h96, ack);
        check("mismatch_addr_nack", ack, NACK);
        check("mismatch_busy", busy_o, 1'b0);
        send_byte(8'h55, ack);
        check("mismatch_data_nack", ack, NACK);
        bus_stop();
        check("mismatch_no_av", av_cnt - av0, 0);
        check("mismatch_sda_never_low", low_cnt - low0, 0);
        compare_writes();

        // Out-of-range pointer.
        wbuf[0] = 8'h77;
        do_write(9, 1);

        // Reset in the middle of a data byte.
        bus_start();
        send_byte(8'h94, ack);
        send_byte(8'h05, ack);
        for (int i = 0; i < 4; i++) send_bit(1'b0);
        reset = 1'b1;
        wait_clk(3);
        check("midrst_sda_o", sda_o, 1'b1);
        check("midrst_state", dbg_state, ST_IDLE);
        scl_m = 1'b1;
        sda_m = 1'b1;
        wait_clk(3);
        reset = 1'b0;
        ref_ptr = 0;
        wait_clk(Q);
        compare_writes();
        wbuf[0] = 8'hC3;
        do_write(3, 1);
        do_read(-1, 1);

        // Randomized transactions against the reference model.
        for (int t = 0; t < 10; t++) begin
            len = $urandom_range(1, 4);
            if ($urandom_range(0, 1) == 1) begin
                for (int k = 0; k < len; k++) wbuf[k] = 8'($urandom_range(0, 255));
                do_write($urandom_range(0, 10), len);
            end else if ($urandom_range(0, 1) == 1) begin
                do_read($urandom_range(0, NUM_REGS - 1), len);
            end else begin
                do_read(-1, len);
            end
        end

`ifdef I2C_GLITCH_FILTER_EN
        // A 2-clk SDA high glitch during an SCL-high 0 bit must not be a STOP.
        bus_start();
        send_byte(8'h94, ack);
        send_byte(8'h01, ack);
        ref_ptr = 1;
        sda_m = 1'b0; wait_clk(Q);
        scl_m = 1'b1; wait_clk(Q);
        sda_m = 1'b1; wait_clk(2);
        sda_m = 1'b0; wait_clk(Q - 2);
        scl_m = 1'b0; wait_clk(Q);
        for (int i = 6; i >= 0; i--) send_bit(i == 5 || i == 2);
        recv_bit(ack);
        check("glitch_data_ack", ack, ACK);
        ref_mem[1] = 8'h24;
        exp_q.push_back({8'h01, 8'h24});
        ref_ptr = 2;
        bus_stop();
        compare_writes();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
